// File: rtl/rotary_pkg.sv
// Shared constants for the rotary event queue: event word width, bit positions
// of each encoder source inside the word, and the empty-word value.
package rotary_pkg;
  localparam int EVT_W    = 3;
  localparam int EVT_PUSH = 0;
  localparam int EVT_ROTR = 1;
  localparam int EVT_ROTL = 2;
  localparam logic [EVT_W-1:0] EVT_NONE = 3'b000;
endpackage

// File: rtl/rotary_edge_detect.sv
// Per-bit rising-edge detector. The previous level clears to 0, so an input
// that is already high when clr is released produces a rise.
module rotary_edge_detect
  import rotary_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic [EVT_W-1:0] lvl,
  output logic [EVT_W-1:0] rise
);
  logic [EVT_W-1:0] prev;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) prev <= '0;
    else     prev <= lvl;
  end

  assign rise = lvl & ~prev;
endmodule

// File: rtl/rotary_event_fifo.sv
// Show-ahead event queue for rotary encoder rises (rotl/rotr/push).
// Optional macro ROTQ_LEVEL_EN exposes the current occupancy on port level.
module rotary_event_fifo
  import rotary_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             rotl,
  input  logic             rotr,
  input  logic             push,
  input  logic             read,
  input  logic             ovf_clr,
  output logic [EVT_W-1:0] out,
  output logic             valid,
  output logic             full,
`ifdef ROTQ_LEVEL_EN
  output logic [AW:0]      level,
`endif
  output logic             overflow
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [EVT_W-1:0] lvl;
  logic [EVT_W-1:0] ev;
  logic [EVT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_pop;
  logic             do_push;

  always_comb begin
    lvl           = '0;
    lvl[EVT_ROTL] = rotl;
    lvl[EVT_ROTR] = rotr;
    lvl[EVT_PUSH] = push;
  end

  rotary_edge_detect u_edge (
    .clk  (clk),
    .clr  (clr),
    .lvl  (lvl),
    .rise (ev)
  );

  // Contract: out holds the head event whenever valid is high; read with valid
  // pops it at the clock edge, read without valid is ignored. A pop on a full
  // queue frees the slot that a same-cycle event then takes.
  assign valid   = (count != '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = read && valid;
  assign do_push = (ev != EVT_NONE) && (!full || do_pop);
  assign out     = valid ? mem[rd_ptr] : EVT_NONE;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= ev;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A drop in the same cycle as ovf_clr keeps the flag set.
      if (ev != EVT_NONE && full && !do_pop) overflow <= 1'b1;
      else if (ovf_clr)                      overflow <= 1'b0;
    end
  end

`ifdef ROTQ_LEVEL_EN
  assign level = count;
`endif
endmodule

// File: tb/tb_rotary_event_fifo.sv
// Self-checking bench for rotary_event_fifo (DEPTH=4): directed scenarios and
// random traffic against a queue-based reference model.
module tb_rotary_event_fifo;
  import rotary_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic rotl = 1'b0, rotr = 1'b0, push = 1'b0, read = 1'b0, ovf_clr = 1'b0;
  logic [EVT_W-1:0] out;
  logic valid, full, overflow;
`ifdef ROTQ_LEVEL_EN
  logic [AW:0] level;
`endif

  rotary_event_fifo #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .clr      (clr),
    .rotl     (rotl),
    .rotr     (rotr),
    .push     (push),
    .read     (read),
    .ovf_clr  (ovf_clr),
    .out      (out),
    .valid    (valid),
    .full     (full),
`ifdef ROTQ_LEVEL_EN
    .level    (level),
`endif
    .overflow (overflow)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: the queue itself is the expected-value store
  logic [EVT_W-1:0] exp_q[$];
  logic [EVT_W-1:0] m_prev = '0;
  logic [EVT_W-1:0] m_lv, m_ev;
  logic             m_ovf = 1'b0;

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      exp_q.delete();
      m_prev = '0;
      m_ovf  = 1'b0;
    end else begin
      m_lv   = {rotl, rotr, push};
      m_ev   = m_lv & ~m_prev;
      m_prev = m_lv;
      if (read && exp_q.size() > 0) void'(exp_q.pop_front());
      if (ovf_clr) m_ovf = 1'b0;
      if (m_ev != 3'b000) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_ev);
        else                      m_ovf = 1'b1;
      end
    end
  end

  // monitor: compare every visible output against the model between edges
  always @(negedge clk) begin
    chk("valid", 8'(valid), 8'(exp_q.size() != 0));
    chk("out", 8'(out), 8'(exp_q.size() != 0 ? exp_q[0] : 3'b000));
    chk("full", 8'(full), 8'(exp_q.size() == DEPTH));
    chk("overflow", 8'(overflow), 8'(m_ovf));
`ifdef ROTQ_LEVEL_EN
    chk("level", 8'(level), 8'(exp_q.size()));
`endif
  end

  // driver: apply inputs after a falling edge, return after the next one
  task automatic cyc(input logic [2:0] lv, input logic rd, input logic oc);
    rotl = lv[2]; rotr = lv[1]; push = lv[0]; read = rd; ovf_clr = oc;
    @(negedge clk);
    #2;
  endtask

  initial begin
    @(negedge clk);
    #2;
    repeat (2) cyc(3'b000, 1'b0, 1'b0);
    chk("rst_valid", 8'(valid), 8'd0);
    clr = 1'b0;
    cyc(3'b000, 1'b0, 1'b0);

    // single events: one-cycle rotl pulse, then rotr held 5 cycles
    cyc(3'b100, 1'b0, 1'b0);
    chk("rotl_lat_out", 8'(out), 8'b100);
    cyc(3'b000, 1'b0, 1'b0);
    repeat (5) cyc(3'b010, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
    cyc(3'b000, 1'b1, 1'b0);
    chk("second_out", 8'(out), 8'b010);
    cyc(3'b000, 1'b1, 1'b0);
    chk("drained_valid", 8'(valid), 8'd0);
    chk("drained_out", 8'(out), 8'd0);

    // merge: rotl and push rise together
    cyc(3'b101, 1'b0, 1'b0);
    chk("merge_out", 8'(out), 8'b101);
    cyc(3'b000, 1'b1, 1'b0);
    chk("merge_single", 8'(valid), 8'd0);

    // fill and overflow: five distinct push pulses
    repeat (5) begin
      cyc(3'b001, 1'b0, 1'b0);
      cyc(3'b000, 1'b0, 1'b0);
    end
    chk("fill_full", 8'(full), 8'd1);
    chk("fill_ovf", 8'(overflow), 8'd1);
    repeat (4) cyc(3'b000, 1'b1, 1'b0);
    chk("fill_empty", 8'(valid), 8'd0);
    chk("ovf_sticky", 8'(overflow), 8'd1);
    cyc(3'b000, 1'b0, 1'b1);
    chk("ovf_cleared", 8'(overflow), 8'd0);

    // full with simultaneous read and new event
    repeat (4) begin
      cyc(3'b001, 1'b0, 1'b0);
      cyc(3'b000, 1'b0, 1'b0);
    end
    cyc(3'b100, 1'b1, 1'b0);
    chk("fullrw_full", 8'(full), 8'd1);
    chk("fullrw_ovf", 8'(overflow), 8'd0);
    repeat (3) cyc(3'b000, 1'b1, 1'b0);
    chk("fullrw_last", 8'(out), 8'b100);
    cyc(3'b000, 1'b1, 1'b0);
    chk("fullrw_empty", 8'(valid), 8'd0);

    // empty queue: read and event in the same cycle
    cyc(3'b001, 1'b1, 1'b0);
    chk("empty_rw_valid", 8'(valid), 8'd1);
    chk("empty_rw_out", 8'(out), 8'b001);
    cyc(3'b000, 1'b1, 1'b0);

    // asynchronous clear with three events queued
    cyc(3'b100, 1'b0, 1'b0);
    cyc(3'b010, 1'b0, 1'b0);
    cyc(3'b001, 1'b0, 1'b0);
    cyc(3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk("aclr_out", 8'(out), 8'd0);
    chk("aclr_valid", 8'(valid), 8'd0);
    chk("aclr_full", 8'(full), 8'd0);
    chk("aclr_ovf", 8'(overflow), 8'd0);
    @(negedge clk);
    #2;
    cyc(3'b001, 1'b0, 1'b0);
    clr = 1'b0;
    cyc(3'b001, 1'b0, 1'b0);
    chk("held_at_release", 8'(out), 8'b001);
    cyc(3'b001, 1'b0, 1'b0);
    cyc(3'b000, 1'b1, 1'b0);
    chk("held_one_event", 8'(valid), 8'd0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [2:0] lv;
      lv  = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      clr = ($urandom_range(0, 199) == 0);
      cyc(lv, ($urandom_range(0, 9) < 4), ($urandom_range(0, 19) == 0));
    end
    clr = 1'b0;
    repeat (6) cyc(3'b000, 1'b1, 1'b0);
    chk("final_empty", 8'(valid), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
